// File: rtl/asic_poc_pkg.sv
// Shared types and helpers for the IO-ring power-on-control sequencer.
package asic_poc_pkg;

  typedef enum logic [2:0] {
    ST_HOLD     = 3'd0,
    ST_DEBOUNCE = 3'd1,
    ST_RELEASE  = 3'd2,
    ST_STAGGER  = 3'd3,
    ST_RUN      = 3'd4
  } state_e;

  // Encodings 5..7 are unreachable; if one appears, fall back to the safe state.
  localparam state_e ST_RECOVER = ST_HOLD;

  // Shared debounce/stagger counter width: must hold max(debounce, stagger).
  function automatic int unsigned cnt_width(input int unsigned deb, input int unsigned stg);
    int unsigned m;
    m = (deb > stg) ? deb : stg;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/asic_poc_sync.sv
// N-stage synchronizer for an asynchronous level input, reset to 0.
module asic_poc_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clk) begin
    if (reset) ff <= '0;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/asic_poc_seq.sv
// Power-on-control sequencer: holds IO pads safe until both supplies are
// stable, then releases poc and enables pad banks one at a time.
module asic_poc_seq
  import asic_poc_pkg::*;
#(
  parameter int unsigned NUM_BANKS       = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STAGGER_CYCLES  = 4,
  parameter int unsigned CNTW            = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 vdd_ok,
  input  logic                 vddio_ok,
  input  logic                 force_hold,
  output logic                 poc,
  output logic [NUM_BANKS-1:0] bank_en,
  output logic                 ready,
  output logic [CNTW-1:0]      brownout_cnt,
  output logic [2:0]           state
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES, STAGGER_CYCLES);
  localparam int unsigned IW = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;

  logic          vdd_ok_s;
  logic          vddio_ok_s;
  logic          sup_ok;
  logic          abort;
  state_e        st;
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  asic_poc_sync #(.STAGES(SYNC_STAGES)) u_sync_vdd (
    .clk   (clk),
    .reset (reset),
    .d     (vdd_ok),
    .q     (vdd_ok_s)
  );

  asic_poc_sync #(.STAGES(SYNC_STAGES)) u_sync_vddio (
    .clk   (clk),
    .reset (reset),
    .d     (vddio_ok),
    .q     (vddio_ok_s)
  );

  assign sup_ok = vdd_ok_s & vddio_ok_s;
  assign abort  = !sup_ok || force_hold;
  assign state  = st;

  // Sequencer FSM with registered pad controls and brownout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= ST_HOLD;
      poc          <= 1'b1;
      bank_en      <= '0;
      ready        <= 1'b0;
      brownout_cnt <= '0;
      cnt          <= '0;
      idx          <= '0;
    end else begin
      case (st)
        ST_HOLD: begin
          poc     <= 1'b1;
          bank_en <= '0;
          ready   <= 1'b0;
          if (sup_ok && !force_hold) begin
            st  <= ST_DEBOUNCE;
            cnt <= '0;
          end
        end

        ST_DEBOUNCE: begin
          if (abort) begin
            st <= ST_HOLD;
          end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
            st <= ST_RELEASE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_RELEASE, ST_STAGGER, ST_RUN: begin
          if (abort) begin
            // Supply loss wins over force_hold for brownout accounting.
            st      <= ST_HOLD;
            poc     <= 1'b1;
            bank_en <= '0;
            ready   <= 1'b0;
            if (!sup_ok && (brownout_cnt != '1)) begin
              brownout_cnt <= brownout_cnt + 1'b1;
            end
          end else if (st == ST_RELEASE) begin
            poc <= 1'b0;
            cnt <= '0;
            idx <= '0;
            st  <= ST_STAGGER;
          end else if (st == ST_STAGGER) begin
            if (cnt == CW'(STAGGER_CYCLES - 1)) begin
              cnt     <= '0;
              bank_en <= bank_en | (NUM_BANKS'(1) << idx);
              idx     <= idx + 1'b1;
              if (idx == IW'(NUM_BANKS - 1)) begin
                ready <= 1'b1;
                st    <= ST_RUN;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        default: begin
          st      <= ST_RECOVER;
          poc     <= 1'b1;
          bank_en <= '0;
          ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule
